sync_frame_tx: RTL and testbench
================================

# sync_frame_tx

Serial frame transmitter that emits the 1011 sync pattern followed by a payload word and a parity bit, one bit per clock. It accepts parallel words over a valid/ready handshake and drives a single-bit line for the team's 1011 sequence detectors and downstream framing receivers. Between frames it holds the line low for a fixed guard gap so that consecutive frames never merge.

## Interface
- DATA_W, 8, payload width in bits (≥1)
- SYNC, 4'b1011, sync pattern, sent MSB first
- GAP, 2, idle low cycles after each frame (≥1)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  DATA_W  payload word, sampled only on accept
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word this cycle
- tx_bit  output  1  serial line
- tx_active  output  1  high while a sync, data or parity bit is on tx_bit
- tx_sof  output  1  high only during the first sync bit
- tx_done  output  1  high only during the parity bit

## Operation
- States: IDLE, SYNC, DATA, PARITY, GAP. All outputs are registered.
- Reset is asynchronous. While rst is high: state=IDLE and in_ready=tx_bit=tx_active=tx_sof=tx_done=0. in_ready rises on the first clk edge after rst is released.
- IDLE: in_ready=1, tx_bit=0. Accept happens at a rising edge with in_valid=1 and in_ready=1.
  - On accept, in_data is copied into a shift register and even parity (XOR of all data bits) is stored. in_data may change afterwards with no effect.
  - Next state is SYNC.
- SYNC: 4 cycles. tx_bit = SYNC[3], SYNC[2], SYNC[1], SYNC[0]. tx_sof=1 during SYNC[3] only.
- DATA: DATA_W cycles. tx_bit shows in_data MSB first.
- PARITY: 1 cycle. tx_bit = stored parity, tx_done=1.
- GAP: GAP cycles. tx_bit=0, tx_active=0, in_ready=0. Then return to IDLE.
- tx_active=1 in SYNC, DATA and PARITY only. in_ready=1 in IDLE only.
- in_valid outside IDLE is ignored. The word stays pending on the producer side and is not consumed.
- Payload containing 1011 is not escaped. Receivers must frame on tx_sof timing.
- Bit counter is sized to ceil(log2(max(DATA_W, GAP, 4)))+1. No wrap-around inside a state.

## Timing
- Accept at edge N → first sync bit is on tx_bit during cycle N+1 (latency 1).
- Frame occupies 4+DATA_W+1 cycles of tx_active. With defaults that is 13 cycles.
- Minimum frame-to-frame period is 1+4+DATA_W+1+GAP cycles. With defaults it is 16.
- With in_valid held high, accepts occur every 16 cycles with defaults.
- Reset mid-frame: all outputs go to 0 immediately and the frame is abandoned (no tx_done). The first accept after release starts a clean frame with SYNC[3].
- in_valid asserted together with the rst release edge is not accepted, because in_ready is still 0.

## Test plan
- Reset: assert rst for 2 cycles mid-simulation → all outputs 0 while rst is high. in_ready=1 one edge after release. tx_bit stays 0 with no traffic.
- Single frame 0xA5 → tx_bit over 13 cycles = 1,0,1,1,1,0,1,0,0,1,0,1,0 (parity 0), then 0,0.
  - tx_sof on cycle 1 only, tx_done on cycle 13 only, tx_active high for exactly 13 cycles.
  - Data bits are cycles 5-12.
- Parity odd: word 0x01 → data bits 0,0,0,0,0,0,0,1, parity bit=1.
- Back-to-back: in_valid held with 0xFF then 0x3C → second tx_sof exactly 16 cycles after the first. Parity 0 for both.
  - in_ready is low for the 15 cycles between the two accepts.
- Busy stall: present a word while the block is in DATA → not accepted. Change in_data mid-frame → the current frame still sends the latched word. The pending word goes out after GAP.
- Reset mid-frame after 3 data bits → tx_active, tx_bit and in_ready drop at the rst edge. No tx_done. A frame 0x81 after release is transmitted correctly from SYNC[3].

Source files
------------

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync pattern, MSB-first payload and even parity bit,
// followed by a fixed low guard gap. All outputs are registered.
module sync_frame_tx #(
  parameter int unsigned DATA_W = 8,
  parameter logic [3:0]  SYNC   = 4'b1011,
  parameter int unsigned GAP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_active,
  output logic              tx_sof,
  output logic              tx_done
);

  localparam int unsigned MaxLen = (DATA_W > GAP) ? ((DATA_W > 4) ? DATA_W : 4)
                                                  : ((GAP > 4) ? GAP : 4);
  localparam int unsigned CntW   = $clog2(MaxLen) + 1;

  typedef enum logic [2:0] {StIdle, StSync, StData, StParity, StGap} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                par_q, par_d;

  logic                in_ready_d, tx_bit_d, tx_active_d, tx_sof_d, tx_done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      par_q   <= par_d;
    end
  end

  // Accept is gated by the registered in_ready so the first edge after reset never accepts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    par_d   = par_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          state_d = StSync;
          cnt_d   = '0;
          data_d  = in_data;
          par_d   = ^in_data;
        end
      end
      StSync: begin
        if (cnt_q == CntW'(3)) begin
          state_d = StData;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntW'(DATA_W - 1)) begin
          state_d = StParity;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + CntW'(1);
          data_d = data_q << 1;
        end
      end
      StParity: begin
        state_d = StGap;
        cnt_d   = '0;
      end
      StGap: begin
        if (cnt_q == CntW'(GAP - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with it after the edge.
  always_comb begin
    in_ready_d  = 1'b0;
    tx_bit_d    = 1'b0;
    tx_active_d = 1'b0;
    tx_sof_d    = 1'b0;
    tx_done_d   = 1'b0;
    unique case (state_d)
      StIdle: in_ready_d = 1'b1;
      StSync: begin
        tx_active_d = 1'b1;
        tx_bit_d    = SYNC[2'd3 - cnt_d[1:0]];
        tx_sof_d    = (cnt_d == '0);
      end
      StData: begin
        tx_active_d = 1'b1;
        tx_bit_d    = data_d[DATA_W-1];
      end
      StParity: begin
        tx_active_d = 1'b1;
        tx_bit_d    = par_d;
        tx_done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b0;
      tx_bit    <= 1'b0;
      tx_active <= 1'b0;
      tx_sof    <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      tx_bit    <= tx_bit_d;
      tx_active <= tx_active_d;
      tx_sof    <= tx_sof_d;
      tx_done   <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx with hand-computed 13-bit frame patterns.
module tb_sync_frame_tx;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx_bit;
  logic       tx_active;
  logic       tx_sof;
  logic       tx_done;

  int checks;
  int failures;

  sync_frame_tx #(
    .DATA_W(8),
    .SYNC  (4'b1011),
    .GAP   (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_bit   (tx_bit),
    .tx_active(tx_active),
    .tx_sof   (tx_sof),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, ".in_ready"}, in_ready, 1'b0);
    chk({tag, ".tx_bit"}, tx_bit, 1'b0);
    chk({tag, ".tx_active"}, tx_active, 1'b0);
    chk({tag, ".tx_sof"}, tx_sof, 1'b0);
    chk({tag, ".tx_done"}, tx_done, 1'b0);
  endtask

  // Called in frame cycle 1 (just after the accept edge); returns in the following idle cycle.
  task automatic check_frame(input string tag, input logic [12:0] exp);
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("%s.bit%0d", tag, i), tx_bit, exp[12-i]);
      chk($sformatf("%s.sof%0d", tag, i), tx_sof, (i == 0));
      chk($sformatf("%s.done%0d", tag, i), tx_done, (i == 12));
      chk($sformatf("%s.active%0d", tag, i), tx_active, 1'b1);
      chk($sformatf("%s.ready%0d", tag, i), in_ready, 1'b0);
      step();
    end
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s.gap%0d", tag, g), {in_ready, tx_bit, tx_active, tx_sof, tx_done} == 5'b0,
          1'b1);
      step();
    end
    chk({tag, ".idle_ready"}, in_ready, 1'b1);
    chk({tag, ".idle_bit"}, tx_bit, 1'b0);
    chk({tag, ".idle_active"}, tx_active, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    step();
    step();
    chk_all_low("por");

    // Release with a word already valid: the first edge must not accept it.
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    #1;
    chk("release.ready_before_edge", in_ready, 1'b0);
    step();
    chk("release.ready_after_edge", in_ready, 1'b1);
    chk("release.not_accepted", tx_active, 1'b0);
    step();
    in_valid = 1'b0;
    in_data  = 8'h00;
    check_frame("a5", 13'b1011_10100101_0);

    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("quiet.bit%0d", i), tx_bit, 1'b0);
      chk($sformatf("quiet.active%0d", i), tx_active, 1'b0);
    end

    in_valid = 1'b1;
    in_data  = 8'h01;
    step();
    in_valid = 1'b0;
    check_frame("p01", 13'b1011_00000001_1);

    // Held valid: 0x3C is presented during 0xFF's frame and must wait for the gap to end.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step();
    in_data  = 8'h3C;
    check_frame("ff", 13'b1011_11111111_0);
    step();
    in_valid = 1'b0;
    check_frame("3c", 13'b1011_00111100_0);

    in_valid = 1'b1;
    in_data  = 8'hF0;
    step();
    in_valid = 1'b0;
    chk("mid.sof", tx_sof, 1'b1);
    for (int i = 0; i < 7; i++) step();
    chk("mid.pre_active", tx_active, 1'b1);
    chk("mid.pre_bit", tx_bit, 1'b1);
    rst = 1'b1;
    #1;
    chk_all_low("mid.async");
    step();
    chk_all_low("mid.hold1");
    step();
    chk_all_low("mid.hold2");

    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h81;
    step();
    chk("rel2.ready", in_ready, 1'b1);
    chk("rel2.not_accepted", tx_active, 1'b0);
    step();
    in_valid = 1'b0;
    check_frame("81", 13'b1011_10000001_0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
